alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_cond.sv | 22 ++
 rtl/alu_seq.sv | 110 +++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op codes, flag bit positions, condition codes and FSM states
package alu_seq_pkg;

    localparam logic [2:0] ALU_OP_ADD = 3'd0;
    localparam logic [2:0] ALU_OP_SUB = 3'd1;
    localparam logic [2:0] ALU_OP_AND = 3'd2;
    localparam logic [2:0] ALU_OP_OR  = 3'd3;
    localparam logic [2:0] ALU_OP_XOR = 3'd4;
    localparam logic [2:0] ALU_OP_SLL = 3'd5;
    localparam logic [2:0] ALU_OP_SRL = 3'd6;
    localparam logic [2:0] ALU_OP_SLT = 3'd7;

    localparam int FLAG_BIT_ZERO     = 0;
    localparam int FLAG_BIT_OVERFLOW = 1;

    localparam logic [1:0] REQ_CMP_NONE = 2'd0;
    localparam logic [1:0] REQ_CMP_EQ   = 2'd1;
    localparam logic [1:0] REQ_CMP_NE   = 2'd2;
    localparam logic [1:0] REQ_CMP_LT   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_cond.sv
// alu_seq_cond: branch-condition and new-overflow decode from the ALU result
module alu_seq_cond
    import alu_seq_pkg::*;
(
    input  logic [1:0] cmp,
    input  logic [2:0] op,
    input  logic       out_lsb,
    input  logic       nflag_zero,
    input  logic       nflag_ov,
    input  logic       flag_ov,
    output logic       taken,
    output logic       new_ov
);

    always_comb begin
        taken  = (cmp == REQ_CMP_EQ) ? nflag_zero :
                 (cmp == REQ_CMP_NE) ? ~nflag_zero :
                 (cmp == REQ_CMP_LT) ? out_lsb : 1'b0;
        new_ov = is_arith(op) & nflag_ov & ~flag_ov;
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequences one request through an external ALU and holds the response
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [5:0]  req_shamt,
    input  logic [1:0]  req_cmp,
    input  logic        req_trap_ov,
    output logic [31:0] alu_x,
    output logic [31:0] alu_y,
    output logic [2:0]  alu_op,
    output logic [5:0]  alu_shamt,
    output logic [31:0] alu_flag,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_nflag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_flag,
    output logic        rsp_taken,
    output logic        rsp_trap,
    output logic [31:0] flag_q,
    input  logic        flag_clr
);

    state_t      state;
    logic [2:0]  op_q;
    logic [31:0] x_q;
    logic [31:0] y_q;
    logic [5:0]  shamt_q;
    logic [1:0]  cmp_q;
    logic        trap_q;
    logic        taken;
    logic        new_ov;
    logic        trap;

    assign alu_x     = x_q;
    assign alu_y     = y_q;
    assign alu_op    = op_q;
    assign alu_shamt = shamt_q;
    assign alu_flag  = flag_q;
    assign trap      = trap_q & new_ov;

    alu_seq_cond u_cond (
        .cmp        (cmp_q),
        .op         (op_q),
        .out_lsb    (alu_out[0]),
        .nflag_zero (alu_nflag[FLAG_BIT_ZERO]),
        .nflag_ov   (alu_nflag[FLAG_BIT_OVERFLOW]),
        .flag_ov    (flag_q[FLAG_BIT_OVERFLOW]),
        .taken      (taken),
        .new_ov     (new_ov)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            shamt_q   <= '0;
            cmp_q     <= '0;
            trap_q    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= '0;
            rsp_taken <= 1'b0;
            rsp_trap  <= 1'b0;
            flag_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q      <= req_op;
                    x_q       <= req_x;
                    y_q       <= req_y;
                    shamt_q   <= req_shamt;
                    cmp_q     <= req_cmp;
                    trap_q    <= req_trap_ov;
                    req_ready <= 1'b0;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    rsp_data  <= alu_out;
                    rsp_flag  <= alu_nflag;
                    rsp_taken <= taken;
                    rsp_trap  <= trap;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // the capture edge owns flag_q; flag_clr only acts on other edges
            flag_q <= (state == ST_ISSUE) ? (trap ? flag_q : alu_nflag) :
                      flag_clr ? '0 : flag_q;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq wired to a behavioural model of the team ALU
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_x = '0;
    logic [31:0] req_y = '0;
    logic [5:0]  req_shamt = '0;
    logic [1:0]  req_cmp = '0;
    logic        req_trap_ov = 1'b0;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [2:0]  alu_op;
    logic [5:0]  alu_shamt;
    logic [31:0] alu_flag;
    logic [31:0] alu_out;
    logic [31:0] alu_nflag;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] rsp_flag;
    logic        rsp_taken;
    logic        rsp_trap;
    logic [31:0] flag_q;
    logic        flag_clr = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_shamt(req_shamt),
        .req_cmp(req_cmp), .req_trap_ov(req_trap_ov),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_flag(alu_flag), .alu_out(alu_out), .alu_nflag(alu_nflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_taken(rsp_taken), .rsp_trap(rsp_trap),
        .flag_q(flag_q), .flag_clr(flag_clr)
    );

    // team ALU: ZERO tracks the result, OVERFLOW is sticky across ADD/SUB
    logic ov_m;
    always_comb begin
        alu_out = (alu_op == ALU_OP_ADD) ? alu_x + alu_y :
                  (alu_op == ALU_OP_SUB) ? alu_x - alu_y :
                  (alu_op == ALU_OP_AND) ? alu_x & alu_y :
                  (alu_op == ALU_OP_OR)  ? alu_x | alu_y :
                  (alu_op == ALU_OP_XOR) ? alu_x ^ alu_y :
                  (alu_op == ALU_OP_SLL) ? alu_x << alu_shamt :
                  (alu_op == ALU_OP_SRL) ? alu_x >> alu_shamt :
                  {31'd0, $signed(alu_x) < $signed(alu_y)};
        ov_m = (alu_op == ALU_OP_ADD) ? (alu_x[31] == alu_y[31]) && (alu_out[31] != alu_x[31]) :
               (alu_op == ALU_OP_SUB) ? (alu_x[31] != alu_y[31]) && (alu_out[31] != alu_x[31]) : 1'b0;
        alu_nflag = alu_flag;
        alu_nflag[FLAG_BIT_ZERO] = (alu_out == 32'd0);
        alu_nflag[FLAG_BIT_OVERFLOW] = alu_flag[FLAG_BIT_OVERFLOW] | ov_m;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic accept(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [5:0] sh, input logic [1:0] cmp, input logic trap_ov);
        req_op = op; req_x = x; req_y = y; req_shamt = sh; req_cmp = cmp; req_trap_ov = trap_ov;
        req_valid = 1'b1;
        chk("ready_before", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_x = 32'hDEAD_BEEF; req_op = ALU_OP_XOR;
        chk("ready_issue", req_ready, 0);
        chk("valid_issue", rsp_valid, 0);
        chk("alu_x", alu_x, x);
        chk("alu_op", alu_op, op);
    endtask

    task automatic capture();
        @(posedge clk); #1;
        chk("valid_resp", rsp_valid, 1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("valid_done", rsp_valid, 0);
        chk("ready_done", req_ready, 1);
    endtask

    task automatic expect_rsp(input logic [31:0] data, input logic [31:0] flag,
                              input logic taken, input logic trap, input logic [31:0] fq);
        chk("rsp_data", rsp_data, data);
        chk("rsp_flag", rsp_flag, flag);
        chk("rsp_taken", rsp_taken, taken);
        chk("rsp_trap", rsp_trap, trap);
        chk("flag_q", flag_q, fq);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_flag", flag_q, 0);
        chk("rst_data", rsp_data, 0);

        accept(ALU_OP_ADD, 32'd5, 32'd7, 6'd0, REQ_CMP_NONE, 1'b0);
        capture();
        expect_rsp(32'd12, 32'd0, 1'b0, 1'b0, 32'd0);
        handshake();

        accept(ALU_OP_SUB, 32'd9, 32'd9, 6'd0, REQ_CMP_EQ, 1'b0);
        capture();
        expect_rsp(32'd0, 32'd1, 1'b1, 1'b0, 32'd1);
        handshake();

        accept(ALU_OP_SUB, 32'd9, 32'd9, 6'd0, REQ_CMP_NE, 1'b0);
        capture();
        expect_rsp(32'd0, 32'd1, 1'b0, 1'b0, 32'd1);
        chk("alu_flag", alu_flag, 32'd1);
        handshake();

        accept(ALU_OP_SLL, 32'd1, 32'd0, 6'd4, REQ_CMP_NONE, 1'b0);
        chk("alu_shamt", alu_shamt, 32'd4);
        capture();
        expect_rsp(32'd16, 32'd0, 1'b0, 1'b0, 32'd0);
        handshake();

        accept(ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 6'd0, REQ_CMP_NONE, 1'b1);
        capture();
        expect_rsp(32'h8000_0000, 32'd2, 1'b0, 1'b1, 32'd0);
        handshake();

        accept(ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 6'd0, REQ_CMP_NONE, 1'b0);
        capture();
        expect_rsp(32'h8000_0000, 32'd2, 1'b0, 1'b0, 32'd2);
        handshake();

        accept(ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 6'd0, REQ_CMP_NONE, 1'b1);
        capture();
        expect_rsp(32'h8000_0000, 32'd2, 1'b0, 1'b0, 32'd2);
        handshake();

        // back-pressure with a second request already waiting
        accept(ALU_OP_ADD, 32'd1, 32'd2, 6'd0, REQ_CMP_LT, 1'b0);
        capture();
        req_op = ALU_OP_XOR; req_x = 32'hF0; req_y = 32'hFF; req_cmp = REQ_CMP_NONE; req_trap_ov = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_data", rsp_data, 32'd3);
            chk("stall_taken", rsp_taken, 1);
            chk("stall_ready", req_ready, 0);
            chk("stall_alu_x", alu_x, 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hs_valid", rsp_valid, 0);
        chk("hs_no_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("second_accept", req_ready, 0);
        chk("second_alu_x", alu_x, 32'hF0);
        capture();
        expect_rsp(32'h0F, 32'd2, 1'b0, 1'b0, 32'd2);
        handshake();

        accept(ALU_OP_SUB, 32'd4, 32'd4, 6'd0, REQ_CMP_EQ, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", rsp_valid, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_flag", flag_q, 0);
        @(posedge clk); #1;
        chk("abort_no_rsp", rsp_valid, 0);

        accept(ALU_OP_ADD, 32'h7FFF_FFFF, 32'd1, 6'd0, REQ_CMP_NONE, 1'b0);
        capture();
        chk("pre_clr_flag", flag_q, 32'd2);
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clr_resp_flag", flag_q, 32'd0);
        chk("clr_resp_valid", rsp_valid, 1);
        handshake();

        accept(ALU_OP_SUB, 32'd3, 32'd3, 6'd0, REQ_CMP_NONE, 1'b0);
        flag_clr = 1'b1;
        capture();
        flag_clr = 1'b0;
        expect_rsp(32'd0, 32'd1, 1'b0, 1'b0, 32'd1);
        handshake();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
